// File: rtl/cv32e40p_sleep_ctrl_md.sv
// Multi-domain sleep controller: one idle-hysteresis FSM and clock gate per domain,
// with a sticky fetch enable and a global core sleep indication.
module cv32e40p_sleep_ctrl_md #(
    parameter int unsigned NUM_DOMAINS = 2,
    parameter int unsigned IDLE_CNT_W  = 4
) (
    input  logic                   clk_ungated_i,
    input  logic                   rst_n,
    input  logic                   scan_cg_en_i,
    input  logic                   fetch_enable_i,
    output logic                   fetch_enable_o,
    input  logic [IDLE_CNT_W-1:0]  idle_thresh_i,
    input  logic [NUM_DOMAINS-1:0] busy_i,
    input  logic [NUM_DOMAINS-1:0] force_on_i,
    input  logic [NUM_DOMAINS-1:0] wake_i,
    output logic [NUM_DOMAINS-1:0] clk_en_o,
    output logic [NUM_DOMAINS-1:0] clk_gated_o,
    output logic [NUM_DOMAINS-1:0] domain_gated_o,
    output logic                   core_sleep_o
);

    typedef enum logic [1:0] {StOff, StRun, StIdle, StGated} state_e;

    state_e                state_q [NUM_DOMAINS];
    state_e                state_d [NUM_DOMAINS];
    logic [IDLE_CNT_W-1:0] cnt_q   [NUM_DOMAINS];
    logic [IDLE_CNT_W-1:0] cnt_d   [NUM_DOMAINS];
    logic                  fetch_enable_q;
    logic                  fetch_enable_d;
    logic [NUM_DOMAINS-1:0] eb;

    assign eb             = busy_i | force_on_i;
    assign fetch_enable_d = fetch_enable_i | fetch_enable_q;
    assign fetch_enable_o = fetch_enable_q;

    always_ff @(posedge clk_ungated_i) begin
        if (!rst_n) begin
            fetch_enable_q <= 1'b0;
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                state_q[d] <= StOff;
                cnt_q[d]   <= '0;
            end
        end else begin
            fetch_enable_q <= fetch_enable_d;
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
        end
    end

    always_comb begin
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            state_d[d] = state_q[d];
            cnt_d[d]   = cnt_q[d];
            unique case (state_q[d])
                StOff: begin
                    if (fetch_enable_d) state_d[d] = StRun;
                end
                StRun: begin
                    if (!eb[d]) begin
                        state_d[d] = StIdle;
                        cnt_d[d]   = '0;
                    end
                end
                StIdle: begin
                    // A threshold lowered below cnt leaves the domain parked here.
                    if (eb[d] || wake_i[d]) begin
                        state_d[d] = StRun;
                    end else if (cnt_q[d] == idle_thresh_i) begin
                        state_d[d] = StGated;
                    end else if (cnt_q[d] < idle_thresh_i) begin
                        cnt_d[d] = cnt_q[d] + 1'b1;
                    end
                end
                StGated: begin
                    if (eb[d] || wake_i[d]) state_d[d] = StRun;
                end
                default: state_d[d] = StOff;
            endcase
        end
    end

    always_comb begin
        clk_en_o       = '0;
        domain_gated_o = '0;
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            unique case (state_q[d])
                StOff:   clk_en_o[d] = 1'b0;
                StRun:   clk_en_o[d] = 1'b1;
                StIdle:  clk_en_o[d] = 1'b1;
                StGated: begin
                    // Wake opens the gate in the same cycle so the waking edge is delivered.
                    clk_en_o[d]       = wake_i[d] | eb[d];
                    domain_gated_o[d] = 1'b1;
                end
                default: clk_en_o[d] = 1'b0;
            endcase
        end
    end

    assign core_sleep_o = fetch_enable_q & (&domain_gated_o) & ~(|clk_en_o);

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : gen_cg
        cv32e40p_clock_gate u_cg (
            .clk_i        (clk_ungated_i),
            .en_i         (clk_en_o[g]),
            .scan_cg_en_i (scan_cg_en_i),
            .clk_o        (clk_gated_o[g])
        );
    end

endmodule

// Latch-based glitch-free clock gate; enable is captured while the clock is low.
module cv32e40p_clock_gate (
    input  logic clk_i,
    input  logic en_i,
    input  logic scan_cg_en_i,
    output logic clk_o
);

    logic en_latch;

    always_latch begin
        if (!clk_i) en_latch <= en_i | scan_cg_en_i;
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl_md.sv
// Directed bench for the multi-domain sleep controller with a per-cycle idle-streak model.
module tb_cv32e40p_sleep_ctrl_md;

    localparam int N = 2;
    localparam int W = 4;

    logic         clk;
    logic         clk_run;
    logic         rst_n;
    logic         scan;
    logic         fe_i;
    logic [W-1:0] thresh;
    logic [N-1:0] busy;
    logic [N-1:0] force_on;
    logic [N-1:0] wake;
    logic         fe_o;
    logic [N-1:0] clk_en;
    logic [N-1:0] clk_gated;
    logic [N-1:0] dgated;
    logic         sleep;

    int checks = 0;
    int errors = 0;

    cv32e40p_sleep_ctrl_md #(
        .NUM_DOMAINS (N),
        .IDLE_CNT_W  (W)
    ) dut (
        .clk_ungated_i  (clk),
        .rst_n          (rst_n),
        .scan_cg_en_i   (scan),
        .fetch_enable_i (fe_i),
        .fetch_enable_o (fe_o),
        .idle_thresh_i  (thresh),
        .busy_i         (busy),
        .force_on_i     (force_on),
        .wake_i         (wake),
        .clk_en_o       (clk_en),
        .clk_gated_o    (clk_gated),
        .domain_gated_o (dgated),
        .core_sleep_o   (sleep)
    );

    initial begin
        clk     = 1'b0;
        clk_run = 1'b1;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a domain is "started" once fetch is enabled; while started and not gated it
    // counts consecutive idle edges (0 = running). Gating happens after thresh+2 idle edges.
    bit           m_valid = 1'b0;
    bit           m_fe;
    bit           m_started [N];
    bit           m_gated   [N];
    int           m_streak  [N];
    logic [W-1:0] m_thresh_prev;

    function automatic logic [N-1:0] exp_clk_en();
        logic [N-1:0] e;
        for (int d = 0; d < N; d++)
            e[d] = m_started[d] & (!m_gated[d] | wake[d] | busy[d] | force_on[d]);
        return e;
    endfunction

    function automatic logic [N-1:0] exp_gated();
        logic [N-1:0] g;
        for (int d = 0; d < N; d++) g[d] = m_gated[d];
        return g;
    endfunction

    always @(posedge clk) begin : model
        bit fe_n;
        bit eb;
        bit all_run;
        if (!rst_n) begin
            m_valid <= 1'b1;
            m_fe    <= 1'b0;
            for (int d = 0; d < N; d++) begin
                m_started[d] <= 1'b0;
                m_gated[d]   <= 1'b0;
                m_streak[d]  <= 0;
            end
        end else if (m_valid) begin
            if (thresh !== m_thresh_prev) begin
                all_run = 1'b1;
                for (int d = 0; d < N; d++)
                    if (!(m_started[d] && !m_gated[d] && m_streak[d] == 0)) all_run = 1'b0;
                check("thresh_change_all_run", 32'(all_run), 32'd1);
            end
            fe_n = fe_i | m_fe;
            m_fe <= fe_n;
            for (int d = 0; d < N; d++) begin
                eb = busy[d] | force_on[d];
                if (!m_started[d]) begin
                    if (fe_n) m_started[d] <= 1'b1;
                end else if (m_gated[d]) begin
                    if (eb || wake[d]) begin
                        m_gated[d]  <= 1'b0;
                        m_streak[d] <= 0;
                    end
                end else if (m_streak[d] == 0) begin
                    if (!eb) m_streak[d] <= 1;
                end else if (eb || wake[d]) begin
                    m_streak[d] <= 0;
                end else if (m_streak[d] == int'(thresh) + 1) begin
                    m_gated[d] <= 1'b1;
                end else begin
                    m_streak[d] <= m_streak[d] + 1;
                end
            end
        end
        m_thresh_prev <= thresh;
    end

    logic [N-1:0] pv_en;
    logic         pv_scan;
    bit           pv_valid = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("fetch_enable_o", 32'(fe_o), 32'(m_fe));
            check("clk_en_o", 32'(clk_en), 32'(exp_clk_en()));
            check("domain_gated_o", 32'(dgated), 32'(exp_gated()));
            check("core_sleep_o", 32'(sleep),
                  32'(m_fe & (&exp_gated()) & ~(|exp_clk_en())));
            check("clk_gated_lo", 32'(clk_gated), 32'd0);
            pv_en    <= exp_clk_en();
            pv_scan  <= scan;
            pv_valid <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (pv_valid) begin
            #1;
            check("clk_gated_hi", 32'(clk_gated), 32'(pv_en | {N{pv_scan}}));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        scan     = 1'b0;
        fe_i     = 1'b0;
        thresh   = 4'd3;
        busy     = 2'b11;
        force_on = 2'b00;
        wake     = 2'b00;
        step(2);
        rst_n = 1'b1;
        step(2);
        check("t1_fe_before", 32'(fe_o), 32'd0);
        check("t1_en_before", 32'(clk_en), 32'd0);

        // Fetch enable pulse
        fe_i = 1'b1;
        step(1);
        fe_i = 1'b0;
        check("t1_fe_after", 32'(fe_o), 32'd1);
        check("t1_en_after", 32'(clk_en), 32'b11);
        step(3);
        check("t1_fe_sticky", 32'(fe_o), 32'd1);

        // Domain 1 goes idle: gated on the 5th edge
        busy = 2'b01;
        step(4);
        check("t2_not_yet", 32'(dgated), 32'b00);
        check("t2_en_still", 32'(clk_en), 32'b11);
        step(1);
        check("t2_gated", 32'(dgated), 32'b10);
        check("t2_en", 32'(clk_en), 32'b01);
        check("t2_sleep", 32'(sleep), 32'd0);

        // Wake domain 1
        wake = 2'b10;
        #1;
        check("t3_comb_wake", 32'(clk_en), 32'b11);
        step(1);
        wake = 2'b00;
        check("t3_run", 32'(dgated), 32'b00);
        step(4);
        check("t3_not_yet", 32'(dgated), 32'b00);
        step(1);
        check("t3_regated", 32'(dgated), 32'b10);

        // Both idle -> sleep, freeze clock
        busy = 2'b00;
        step(4);
        check("t4_no_sleep", 32'(sleep), 32'd0);
        step(1);
        check("t4_sleep", 32'(sleep), 32'd1);
        check("t4_all_gated", 32'(dgated), 32'b11);
        check("t4_en_off", 32'(clk_en), 32'd0);
        @(negedge clk);
        clk_run = 1'b0;
        #503;
        clk_run = 1'b1;
        step(1);
        check("t4_sleep_kept", 32'(sleep), 32'd1);
        check("t4_gated_kept", 32'(dgated), 32'b11);
        check("t4_fe_kept", 32'(fe_o), 32'd1);
        wake = 2'b01;
        #1;
        check("t4_wake_sleep", 32'(sleep), 32'd0);
        check("t4_wake_en", 32'(clk_en), 32'b01);

        // Force domain 0 on, bring domain 1 back to run
        step(1);
        wake     = 2'b00;
        force_on = 2'b01;
        busy     = 2'b10;
        check("t5_d0_run", 32'(dgated), 32'b10);
        step(1);
        thresh = 4'd0;
        step(99);
        check("t5_forced_sleep", 32'(sleep), 32'd0);
        check("t5_forced_en", 32'(clk_en), 32'b11);
        check("t5_forced_gated", 32'(dgated), 32'b00);
        force_on = 2'b00;
        step(1);
        check("t5_idle", 32'(dgated), 32'b00);
        step(1);
        check("t5_gated", 32'(dgated), 32'b01);

        // Reset while domain 1 is idle with cnt = 2
        force_on = 2'b01;
        step(1);
        thresh = 4'd3;
        step(1);
        busy = 2'b00;
        step(3);
        check("t6_pre_gated", 32'(dgated), 32'b00);
        check("t6_pre_en", 32'(clk_en), 32'b11);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("t6_rst_fe", 32'(fe_o), 32'd0);
        check("t6_rst_en", 32'(clk_en), 32'd0);
        check("t6_rst_gated", 32'(dgated), 32'd0);
        check("t6_rst_sleep", 32'(sleep), 32'd0);
        force_on = 2'b00;
        step(10);
        check("t6_en_off", 32'(clk_en), 32'd0);
        scan = 1'b1;
        @(posedge clk);
        #1;
        check("t6_scan_hi", 32'(clk_gated), 32'b11);
        @(negedge clk);
        #1;
        check("t6_scan_lo", 32'(clk_gated), 32'b00);
        check("t6_scan_en", 32'(clk_en), 32'd0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
